// File: rtl/mem_bus_pkg.sv
// Shared definitions for the byte-bus memory master: size codes, FSM states,
// bus address width and the default response timeout.
package mem_bus_pkg;

   localparam int ADDR_W                 = 12;
   localparam int DEFAULT_TIMEOUT_CYCLES = 15;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   // Code 11 is folded into a full word transfer.
   function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
      logic [2:0] n;
      case (size)
         SIZE_B:  n = 3'd1;
         SIZE_H:  n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled little-endian load value.
// Byte and half results are extended; word (and code 11) passes through.
module load_extend
   import mem_bus_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   always_comb begin
      result = raw;
      case (size)
         SIZE_B:  result = is_unsigned ? {24'd0, raw[7:0]}
                                       : {{24{raw[7]}}, raw[7:0]};
         SIZE_H:  result = is_unsigned ? {16'd0, raw[15:0]}
                                       : {{16{raw[15]}}, raw[15:0]};
         default: result = raw;
      endcase
   end

endmodule

// File: rtl/mem_byte_master.sv
// Splits byte/half/word loads and stores into single-byte bus transactions.
// Optional response timeout is compiled in with MEM_BYTE_MASTER_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for i_start; command registers hold last transfer
// ST_REQ  | one-cycle byte request for lane k
// ST_WAIT | waiting for i_bus_data_DV (or timeout, when compiled in)
// ST_DONE | one-cycle completion pulse with result/error
module mem_byte_master
   import mem_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_we,
   input  logic [1:0]        i_size,
   input  logic              i_unsigned,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic [31:0]       o_rdata,
   output logic              o_error,
   output logic              o_bus_request,
   output logic              o_bus_write,
   output logic [ADDR_W-1:0] o_bus_address,
   output logic [7:0]        o_bus_data,
   input  logic [7:0]        i_bus_data,
   input  logic              i_bus_data_DV
);

   state_t              state, state_nx;
   logic                we_q;
   logic [1:0]          size_q;
   logic                unsigned_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [2:0]          n_q;
   logic [2:0]          k_q;
   logic [31:0]         raw_q;
   logic [31:0]         ext_data;
   logic                timeout_hit;
   logic                err_flag;
   logic [4:0]          lane_lsb;

   assign lane_lsb = {k_q[1:0], 3'b000};

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= ST_IDLE;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         n_q        <= 3'd0;
         k_q        <= 3'd0;
         raw_q      <= '0;
      end else begin
         state <= state_nx;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  we_q       <= i_we;
                  size_q     <= i_size;
                  unsigned_q <= i_unsigned;
                  addr_q     <= i_addr;
                  wdata_q    <= i_wdata;
                  n_q        <= size_to_bytes(i_size);
                  k_q        <= 3'd0;
                  raw_q      <= '0;
               end
            end
            ST_WAIT: begin
               if (i_bus_data_DV) begin
                  if (!we_q) raw_q[lane_lsb +: 8] <= i_bus_data;
                  k_q <= k_q + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MEM_BYTE_MASTER_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   // Down-counter loaded on the way into WAIT; terminal count is zero.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == ST_IDLE && i_start)
            err_q <= 1'b0;
         else if (timeout_hit)
            err_q <= 1'b1;

         if (state == ST_REQ)
            wait_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
         else if (state == ST_WAIT && !i_bus_data_DV && wait_cnt != '0)
            wait_cnt <= wait_cnt - 1'b1;
      end
   end

   assign timeout_hit = (state == ST_WAIT) && !i_bus_data_DV && (wait_cnt == '0);
   assign err_flag    = err_q;
`else
   logic [31:0] unused_timeout;

   assign unused_timeout = 32'(TIMEOUT_CYCLES);
   assign timeout_hit    = 1'b0;
   assign err_flag       = 1'b0;
`endif

   load_extend u_load_extend (
      .raw         (raw_q),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .result      (ext_data)
   );

   always_comb begin
      state_nx      = state;
      o_busy        = (state != ST_IDLE);
      o_done        = 1'b0;
      o_rdata       = '0;
      o_error       = 1'b0;
      o_bus_request = 1'b0;
      o_bus_write   = 1'b0;
      o_bus_address = '0;
      o_bus_data    = '0;
      case (state)
         ST_IDLE: begin
            if (i_start) state_nx = ST_REQ;
         end
         ST_REQ: begin
            o_bus_request = 1'b1;
            o_bus_write   = we_q;
            o_bus_address = addr_q + {{(ADDR_W-3){1'b0}}, k_q};
            o_bus_data    = wdata_q[lane_lsb +: 8];
            state_nx      = ST_WAIT;
         end
         ST_WAIT: begin
            if (i_bus_data_DV)
               state_nx = ((k_q + 3'd1) < n_q) ? ST_REQ : ST_DONE;
            else if (timeout_hit)
               state_nx = ST_DONE;
         end
         ST_DONE: begin
            o_done   = 1'b1;
            o_error  = err_flag;
            o_rdata  = (we_q || err_flag) ? 32'd0 : ext_data;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_byte_master.sv
// Self-checking bench for mem_byte_master with a one-cycle byte responder
// and a byte-array reference model; timeout case follows MEM_BYTE_MASTER_TIMEOUT_EN.
module tb_mem_byte_master;

   localparam int TO = 15;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_start = 1'b0;
   logic        i_we = 1'b0;
   logic [1:0]  i_size = 2'b00;
   logic        i_unsigned = 1'b0;
   logic [11:0] i_addr = '0;
   logic [31:0] i_wdata = '0;
   logic        o_busy, o_done, o_error;
   logic [31:0] o_rdata;
   logic        o_bus_request, o_bus_write;
   logic [11:0] o_bus_address;
   logic [7:0]  o_bus_data;
   logic [7:0]  i_bus_data;
   logic        i_bus_data_DV;

   mem_byte_master #(.TIMEOUT_CYCLES(TO)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_start       (i_start),
      .i_we          (i_we),
      .i_size        (i_size),
      .i_unsigned    (i_unsigned),
      .i_addr        (i_addr),
      .i_wdata       (i_wdata),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_rdata       (o_rdata),
      .o_error       (o_error),
      .o_bus_request (o_bus_request),
      .o_bus_write   (o_bus_write),
      .o_bus_address (o_bus_address),
      .o_bus_data    (o_bus_data),
      .i_bus_data    (i_bus_data),
      .i_bus_data_DV (i_bus_data_DV)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad = 0;

   // Responder memory (written by DUT) and reference memory (written by model).
   bit [7:0]    mem [4096];
   bit [7:0]    ref_mem [4096];
   logic [7:0]  rd_q = '0;
   logic        dv_q = 1'b0;
   logic        silent = 1'b0;
   logic        spur = 1'b0;

   assign i_bus_data    = rd_q;
   assign i_bus_data_DV = dv_q | spur;

   always @(posedge i_clk) begin
      dv_q <= 1'b0;
      if (o_bus_request) begin
         if (o_bus_write) mem[o_bus_address] <= o_bus_data;
         else rd_q <= mem[o_bus_address];
         dv_q <= !silent;
      end
   end

   int          req_count = 0;
   int          req_viol = 0;
   logic        prev_req = 1'b0;
   logic [19:0] wlog [$];

   always @(posedge i_clk) begin
      prev_req <= o_bus_request;
      if (o_bus_request) begin
         req_count <= req_count + 1;
         if (prev_req) req_viol <= req_viol + 1;
         if (o_bus_write) wlog.push_back({o_bus_address, o_bus_data});
      end
   end

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [11:0] a, input logic [1:0] sz,
                                            input logic uns);
      int     n = nbytes(sz);
      longint v = 0;
      for (int i = 0; i < n; i++)
         v += longint'(ref_mem[(int'(a) + i) % 4096]) << (8 * i);
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
         v -= (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   task automatic ref_store(input logic [11:0] a, input logic [1:0] sz, input logic [31:0] wd);
      for (int i = 0; i < nbytes(sz); i++)
         ref_mem[(int'(a) + i) % 4096] = 8'((wd >> (8 * i)) & 32'hFF);
   endtask

   // Runs one transfer; cyc counts edges from the i_start sampling edge to o_done.
   task automatic do_xfer(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [11:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int cyc);
      @(negedge i_clk);
      i_we = we; i_size = sz; i_unsigned = uns; i_addr = a; i_wdata = wd; i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      cyc = 1;
      while (!o_done && cyc < 200) begin
         @(posedge i_clk); #1;
         cyc++;
      end
      rd = o_rdata;
      er = o_error;
      @(posedge i_clk); #1;
   endtask

   task automatic test_reset;
      #2;
      total++;
      if ({o_busy, o_done, o_bus_request, o_bus_write, o_error} !== 5'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b want=00000",
                         {o_busy, o_done, o_bus_request, o_bus_write, o_error});
      end
      repeat (2) @(posedge i_clk);
      #1;
      total++;
      if (o_rdata !== 32'd0 || o_bus_address !== 12'd0 || o_bus_data !== 8'd0) begin
         bad++; $display("FAIL reset_data rdata=%h addr=%h data=%h want 0", o_rdata,
                         o_bus_address, o_bus_data);
      end
      @(negedge i_clk);
      i_reset = 1'b0;
   endtask

   task automatic test_spec_vectors;
      logic [31:0] rd;
      logic        er;
      int          cyc;
      logic [19:0] exp_log [4];
      logic [11:0] la [4];
      logic [1:0]  ls [4];
      logic        lu [4];
      logic [31:0] le [4];
      int          ll [4];
      exp_log = '{ {12'h010, 8'hEF}, {12'h011, 8'hBE}, {12'h012, 8'hAD}, {12'h013, 8'hDE} };
      la = '{12'h010, 12'h013, 12'h013, 12'h012};
      ls = '{2'd2, 2'd0, 2'd0, 2'd1};
      lu = '{1'b0, 1'b0, 1'b1, 1'b0};
      le = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD};
      ll = '{9, 3, 3, 5};
      wlog.delete();
      do_xfer(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, rd, er, cyc);
      ref_store(12'h010, 2'd2, 32'hDEADBEEF);
      total++;
      if (cyc !== 9) begin bad++; $display("FAIL word_store_latency got=%0d want=9", cyc); end
      total++;
      if (rd !== 32'd0) begin bad++; $display("FAIL store_rdata got=%h want=0", rd); end
      total++;
      if (wlog.size() !== 4) begin
         bad++; $display("FAIL word_store_beats got=%0d want=4", wlog.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (wlog[i] !== exp_log[i]) begin
               bad++; $display("FAIL word_store_byte%0d got=%h want=%h", i, wlog[i], exp_log[i]);
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         do_xfer(1'b0, ls[i], lu[i], la[i], 32'd0, rd, er, cyc);
         total++;
         if (rd !== le[i]) begin bad++; $display("FAIL load%0d_data got=%h want=%h", i, rd, le[i]); end
         total++;
         if (cyc !== ll[i]) begin bad++; $display("FAIL load%0d_latency got=%0d want=%0d", i, cyc, ll[i]); end
      end
      total++;
      if (req_viol !== 0) begin bad++; $display("FAIL req_single_cycle got=%0d want=0", req_viol); end
   endtask

   task automatic test_wrap;
      logic [31:0] rd;
      logic        er;
      int          cyc;
      wlog.delete();
      do_xfer(1'b1, 2'd1, 1'b0, 12'hFFF, 32'h0000A55A, rd, er, cyc);
      ref_store(12'hFFF, 2'd1, 32'h0000A55A);
      total++;
      if (wlog.size() !== 2 || wlog[0] !== {12'hFFF, 8'h5A} || wlog[1] !== {12'h000, 8'hA5}) begin
         bad++; $display("FAIL wrap_store n=%0d b0=%h b1=%h want fff5a 000a5", wlog.size(),
                         (wlog.size() > 0) ? wlog[0] : 20'h0, (wlog.size() > 1) ? wlog[1] : 20'h0);
      end
      do_xfer(1'b0, 2'd1, 1'b1, 12'hFFF, 32'd0, rd, er, cyc);
      total++;
      if (rd !== 32'h0000A55A) begin bad++; $display("FAIL wrap_load got=%h want=0000a55a", rd); end
   endtask

   task automatic test_random;
      logic [31:0] rd, wd, exp;
      logic        er, we, uns;
      logic [1:0]  sz;
      logic [11:0] a;
      int          cyc, n;
      for (int t = 0; t < 60; t++) begin
         we  = (t < 16) ? 1'b1 : 1'($urandom_range(0, 1));
         sz  = 2'($urandom_range(0, 3));
         uns = 1'($urandom_range(0, 1));
         a   = (t % 9 == 8) ? 12'(12'hFFD + $urandom_range(0, 2)) : 12'(12'h100 + $urandom_range(0, 63));
         wd  = $urandom;
         n   = nbytes(sz);
         exp = we ? 32'd0 : ref_load(a, sz, uns);
         do_xfer(we, sz, uns, a, wd, rd, er, cyc);
         if (we) ref_store(a, sz, wd);
         total++;
         if (rd !== exp || er !== 1'b0) begin
            bad++; $display("FAIL rand%0d_data we=%0d sz=%0d a=%h got=%h/%b want=%h/0", t, we, sz,
                            a, rd, er, exp);
         end
         total++;
         if (cyc !== 2 * n + 1) begin
            bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", t, cyc, 2 * n + 1);
         end
      end
   endtask

   task automatic test_busy_start;
      logic [31:0] exp, rd;
      int          base, cyc;
      exp  = ref_load(12'h120, 2'd2, 1'b0);
      base = req_count;
      @(negedge i_clk);
      i_we = 1'b0; i_size = 2'd2; i_unsigned = 1'b0; i_addr = 12'h120; i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      cyc = 1;
      while (!o_done && cyc < 200) begin
         @(negedge i_clk);
         i_start = (cyc == 2 || cyc == 5);
         i_addr  = 12'h130;
         @(posedge i_clk); #1;
         cyc++;
      end
      i_start = 1'b0;
      rd = o_rdata;
      @(negedge i_clk);
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      repeat (12) @(posedge i_clk);
      #1;
      total++;
      if (rd !== exp || cyc !== 9) begin
         bad++; $display("FAIL busy_xfer got=%h/%0d want=%h/9", rd, cyc, exp);
      end
      total++;
      if (req_count - base !== 4 || o_busy !== 1'b0) begin
         bad++; $display("FAIL busy_no_queue reqs=%0d busy=%b want 4/0", req_count - base, o_busy);
      end
   endtask

   task automatic test_idle_dv;
      @(negedge i_clk);
      spur = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge i_clk); #1;
         total++;
         if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            bad++; $display("FAIL idle_dv%0d busy=%b done=%b want 0/0", i, o_busy, o_done);
         end
      end
      @(negedge i_clk);
      spur = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [31:0] wd, rd, exp;
      logic        er;
      int          cyc;
      wd = $urandom;
      @(negedge i_clk);
      i_we = 1'b1; i_size = 2'd2; i_addr = 12'h140; i_wdata = wd; i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      @(posedge i_clk); #1;
      total++;
      if (o_busy !== 1'b1 || o_bus_request !== 1'b0) begin
         bad++; $display("FAIL mid_wait_state busy=%b req=%b want 1/0", o_busy, o_bus_request);
      end
      #1 i_reset = 1'b1;
      #1;
      total++;
      if (o_busy !== 1'b0 || o_bus_request !== 1'b0 || o_done !== 1'b0) begin
         bad++; $display("FAIL mid_reset busy=%b req=%b done=%b want 000", o_busy, o_bus_request, o_done);
      end
      ref_mem[12'h140] = wd[7:0];
      @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
      exp = ref_load(12'h140, 2'd2, 1'b0);
      do_xfer(1'b0, 2'd2, 1'b0, 12'h140, 32'd0, rd, er, cyc);
      total++;
      if (rd !== exp || cyc !== 9) begin
         bad++; $display("FAIL after_reset got=%h/%0d want=%h/9", rd, cyc, exp);
      end
   endtask

   task automatic test_timeout;
      logic [31:0] rd, exp;
      logic        er;
      int          cyc;
`ifdef MEM_BYTE_MASTER_TIMEOUT_EN
      silent = 1'b1;
      do_xfer(1'b0, 2'd2, 1'b0, 12'h100, 32'd0, rd, er, cyc);
      silent = 1'b0;
      total++;
      if (er !== 1'b1 || rd !== 32'd0 || cyc !== TO + 2) begin
         bad++; $display("FAIL timeout got err=%b rd=%h cyc=%0d want 1/0/%0d", er, rd, cyc, TO + 2);
      end
`else
      int low;
      silent = 1'b1;
      @(negedge i_clk);
      i_we = 1'b0; i_size = 2'd0; i_addr = 12'h100; i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      low = 0;
      repeat (100) begin
         @(posedge i_clk); #1;
         if (o_busy !== 1'b1 || o_error !== 1'b0) low++;
      end
      total++;
      if (low !== 0) begin bad++; $display("FAIL hang_busy bad_cycles=%0d want=0", low); end
      @(negedge i_clk);
      i_reset = 1'b1;
      silent = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
`endif
      exp = ref_load(12'h101, 2'd0, 1'b1);
      do_xfer(1'b0, 2'd0, 1'b1, 12'h101, 32'd0, rd, er, cyc);
      total++;
      if (rd !== exp || er !== 1'b0 || cyc !== 3) begin
         bad++; $display("FAIL post_timeout got=%h/%b/%0d want=%h/0/3", rd, er, cyc, exp);
      end
   endtask

   task automatic test_memory_image;
      int diffs = 0;
      for (int i = 0; i < 4096; i++)
         if (mem[i] !== ref_mem[i]) diffs++;
      total++;
      if (diffs !== 0) begin bad++; $display("FAIL memory_image diffs=%0d want=0", diffs); end
   endtask

   initial begin
      test_reset;
      test_spec_vectors;
      test_wrap;
      test_random;
      test_busy_start;
      test_idle_dv;
      test_reset_mid;
      test_timeout;
      test_memory_image;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/mem_byte_master.md
MEM_BYTE_MASTER -- requirements
Module: mem_byte_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, SHALL set the maximum wait cycles for a byte response; used only when the timeout feature is compiled in.
REQ-002 i_clk  in  1  SHALL be the single clock; every register SHALL update on its rising edge.
REQ-003 i_reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-004 i_start  in  1  SHALL request a transfer; it SHALL be sampled only in IDLE.
REQ-005 i_we  in  1  SHALL select the transfer type: 1 = store, 0 = load.
REQ-006 i_size  in  2  SHALL give the transfer size: 00 = byte, 01 = half, 10 = word; 11 SHALL be treated as word.
REQ-007 i_unsigned  in  1  SHALL select load extension: 1 = zero-extend, 0 = sign-extend.
REQ-008 i_addr  in  12  SHALL be the start byte address.
REQ-009 i_wdata  in  32  SHALL be the store data, little-endian.
REQ-010 o_busy  out  1  SHALL be high in every state except IDLE.
REQ-011 o_done  out  1  SHALL be a one-cycle completion pulse.
REQ-012 o_rdata  out  32  SHALL be the extended load result, valid while o_done is high.
REQ-013 o_error  out  1  SHALL flag a timeout, valid while o_done is high.
REQ-014 o_bus_request, o_bus_write  out  1 each  SHALL be the byte-bus request and write qualifier.
REQ-015 o_bus_address  out  12, o_bus_data  out  8  SHALL be the byte-bus address and write data.
REQ-016 i_bus_data  in  8, i_bus_data_DV  in  1  SHALL be the byte-bus read data and its data-valid strobe.

Function
REQ-017 States SHALL be IDLE, REQ, WAIT and DONE.
REQ-018 In IDLE, i_start=1 SHALL latch i_we, i_size, i_unsigned, i_addr and i_wdata, set the byte count N to 1, 2 or 4, clear the byte index k, and go to REQ.
REQ-019 In REQ, for exactly one cycle: o_bus_request=1, o_bus_write=latched we, o_bus_address=addr+k (12-bit wrap, 0xFFF+1=0x000), o_bus_data=wdata[8k+7:8k]; the next state SHALL be WAIT.
REQ-020 In WAIT, o_bus_request SHALL be 0; on i_bus_data_DV=1, a load SHALL capture i_bus_data into byte lane k, k SHALL increment, and the next state SHALL be REQ if k+1<N, else DONE.
REQ-021 i_bus_data_DV outside WAIT SHALL be ignored.
REQ-022 DONE SHALL last one cycle with o_done=1, then return to IDLE; o_done and o_rdata SHALL be 0 in all other states.
REQ-023 Latency with a one-cycle responder SHALL be 2N+1 edges from i_start sampled to o_done: byte 3, half 5, word 9.
REQ-024 Load result: byte/half SHALL be sign- or zero-extended per i_unsigned; word SHALL be passed unmodified; a store SHALL return o_rdata=0.
REQ-025 Unaligned addresses SHALL be legal, with no alignment fault.
REQ-026 i_start while busy SHALL be ignored and SHALL NOT be queued.

Reset
REQ-027 Asserting i_reset, including mid-transfer, SHALL immediately force IDLE; every output and all internal registers SHALL go to 0.
REQ-028 The first transfer after reset release SHALL be accepted on the first edge with i_start=1.

Configuration
REQ-029 With MEM_BYTE_MASTER_TIMEOUT_EN defined:
- a wait counter SHALL clear on entry to WAIT;
- if TIMEOUT_CYCLES cycles pass in WAIT without DV, the next state SHALL be DONE with o_error=1 and o_rdata=0;
- remaining bytes SHALL be abandoned.
REQ-030 Without MEM_BYTE_MASTER_TIMEOUT_EN: WAIT SHALL hold indefinitely, no counter SHALL be built, and o_error SHALL be tied 0.

Structure
REQ-031 Shared package mem_bus_pkg SHALL hold the size encodings (SIZE_B/H/W), the state enum, the address width (12) and the default TIMEOUT_CYCLES.
REQ-032 Load extension SHALL be a sub-module load_extend (32-bit raw + size + unsigned -> 32-bit result); the FSM and datapath SHALL remain in mem_byte_master.

Verification (one-cycle byte-responder model, 64+ bytes)
REQ-033 Word store 0xDEADBEEF @0x010 -> bus writes EF@010, BE@011, AD@012, DE@013, each o_bus_request exactly one cycle; o_done 9 edges after i_start.
REQ-034 Word load @0x010 -> o_rdata=0xDEADBEEF; signed byte load @0x013 -> 0xFFFFFFDE; unsigned -> 0x000000DE; signed half load @0x012 -> 0xFFFFDEAD.
REQ-035 Half store 0xA55A @0xFFF -> writes 5A@FFF, A5@000 (wrap).
REQ-036 i_start pulsed during a word transfer -> exactly one transfer; i_reset in WAIT -> o_busy, o_bus_request and o_done all 0 before the next edge, and a new transfer then runs normally.
REQ-037 Responder never raises DV, TIMEOUT_CYCLES=15, macro defined -> o_done with o_error=1 and o_rdata=0 after 15 WAIT cycles; macro undefined -> o_busy stays 1 for 100 cycles.
